ro_puf_bank: RTL



---
 rtl/ro_puf_pkg.sv | 21 ++
 rtl/osc_ring_n.sv | 49 ++++
 rtl/ro_puf_bank.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF bank.
`timescale 1ns/1ps
package ro_puf_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int CLR_CYC    = 2;
  localparam int SETTLE_CYC = 4;

  function automatic bit stages_ok(input int stages);
    return (stages >= 3) && (stages % 2 == 1);
  endfunction

endpackage

// File: rtl/osc_ring_n.sv
// Enable-gated ring oscillator: NAND(enable, feedback) followed by STAGES-1 inverters.
// Output rests high while disabled; simulation builds swap in a timed behavioural ring.
`timescale 1ns/1ps
module osc_ring_n
  import ro_puf_pkg::*;
#(
  parameter int STAGES      = 5,
  parameter int RING_ID     = 0,
  parameter int SIM_HALF_PS = 5000
) (
  input  logic i_en,
  output logic o_ring
);

  if (!stages_ok(STAGES)) begin : g_bad_stages
    $error("osc_ring_n: STAGES must be odd and at least 3");
  end

`ifndef SYNTHESIS
  int   r_half_ps;
  logic r_osc;

  initial begin
    r_half_ps = SIM_HALF_PS;
  end

  // Dropping the enable forces the NAND output high, so the ring parks high.
  always begin
    r_osc = 1'b1;
    wait (i_en);
    while (i_en) begin
      #(real'(r_half_ps) / 1000.0);
      if (i_en) r_osc = ~r_osc;
    end
  end

  assign o_ring = r_osc;
`else
  logic [STAGES-1:0] w_node;

  assign w_node[0] = ~(i_en & w_node[STAGES-1]);
  for (genvar gi = 1; gi < STAGES; gi++) begin : g_inv
    assign w_node[gi] = ~w_node[gi-1];
  end

  assign o_ring = w_node[STAGES-1];
`endif

endmodule

// File: rtl/ro_puf_bank.sv
// Bank of gated ring oscillators with a pairwise count-and-compare engine;
// each challenge yields one response bit from the faster of two selected rings.
`timescale 1ns/1ps
module ro_puf_bank
  import ro_puf_pkg::*;
#(
  parameter int NUM_RINGS = 8,
  parameter int STAGES    = 5,
  parameter int CNT_W     = 16,
  parameter int WIN_W     = 16,
  parameter int SEL_W     = $clog2(NUM_RINGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] sel_a,
  input  logic [SEL_W-1:0] sel_b,
  input  logic [WIN_W-1:0] window_len,
  output logic             busy,
  output logic             done,
  output logic             resp_bit,
  output logic             tie,
  output logic             err,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  state_t               r_state, w_state_nxt;
  logic [WIN_W-1:0]     r_tmr, w_tmr_nxt, r_win_len;
  logic [SEL_W-1:0]     r_sel_a, r_sel_b, w_sel_a_eff, w_sel_b_eff;
  logic                 w_illegal, w_accept;
  logic [NUM_RINGS-1:0] w_pair_mask, r_ring_en, r_ring_clr, w_ring, w_cnt_clr;
  logic [CNT_W-1:0]     w_ring_cnt [NUM_RINGS];
  logic [CNT_W-1:0]     w_cnt_a, w_cnt_b, r_cnt_a, r_cnt_b;
  logic                 r_resp, r_tie, r_err;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_illegal = (sel_a == sel_b) || (int'(sel_a) >= NUM_RINGS) ||
                     (int'(sel_b) >= NUM_RINGS) || (window_len == '0);

  // In IDLE the mask must follow the live inputs so CLEAR hits the right rings on entry.
  assign w_sel_a_eff = (r_state == IDLE) ? sel_a : r_sel_a;
  assign w_sel_b_eff = (r_state == IDLE) ? sel_b : r_sel_b;

  always_comb begin
    w_pair_mask = '0;
    w_pair_mask[w_sel_a_eff] = 1'b1;
    w_pair_mask[w_sel_b_eff] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_illegal) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = CLEAR;
            w_tmr_nxt   = WIN_W'(CLR_CYC - 1);
          end
        end
      end
      CLEAR: begin
        if (r_tmr == '0) begin
          w_state_nxt = RUN;
          w_tmr_nxt   = r_win_len - WIN_W'(1);
        end else begin
          w_tmr_nxt = r_tmr - WIN_W'(1);
        end
      end
      RUN: begin
        if (r_tmr == '0) begin
          w_state_nxt = SETTLE;
          w_tmr_nxt   = WIN_W'(SETTLE_CYC - 1);
        end else begin
          w_tmr_nxt = r_tmr - WIN_W'(1);
        end
      end
      SETTLE: begin
        if (r_tmr == '0) w_state_nxt = CAPTURE;
        else             w_tmr_nxt   = r_tmr - WIN_W'(1);
      end
      CAPTURE: w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Enables and clears are registered so ring gating never sees decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tmr      <= '0;
      r_win_len  <= '0;
      r_sel_a    <= '0;
      r_sel_b    <= '0;
      r_ring_en  <= '0;
      r_ring_clr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_ring_en  <= (w_state_nxt == RUN)   ? w_pair_mask : '0;
      r_ring_clr <= (w_state_nxt == CLEAR) ? w_pair_mask : '0;
      if (w_accept) begin
        r_sel_a   <= sel_a;
        r_sel_b   <= sel_b;
        r_win_len <= window_len;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RINGS; gi++) begin : g_ring
    logic [CNT_W-1:0] r_cnt;

    osc_ring_n #(
      .STAGES  (STAGES),
      .RING_ID (gi)
    ) u_osc (
      .i_en   (r_ring_en[gi]),
      .o_ring (w_ring[gi])
    );

    assign w_cnt_clr[gi] = r_ring_clr[gi] | ~rst_n;

    always_ff @(posedge w_ring[gi] or posedge w_cnt_clr[gi]) begin
      if (w_cnt_clr[gi])    r_cnt <= '0;
      else if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign w_ring_cnt[gi] = r_cnt;
  end

  // Counters are static by CAPTURE (rings stopped through SETTLE), so no synchronizer.
  assign w_cnt_a = w_ring_cnt[r_sel_a];
  assign w_cnt_b = w_ring_cnt[r_sel_b];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_resp  <= 1'b0;
      r_tie   <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_resp  <= 1'b0;
      r_tie   <= 1'b0;
      r_err   <= 1'b1;
    end else if (r_state == CAPTURE) begin
      r_cnt_a <= w_cnt_a;
      r_cnt_b <= w_cnt_b;
      r_resp  <= (w_cnt_a > w_cnt_b);
      r_tie   <= (w_cnt_a == w_cnt_b);
      r_err   <= (w_cnt_a == '1) || (w_cnt_b == '1);
    end
  end

  assign busy     = (r_state == CLEAR) || (r_state == RUN) ||
                    (r_state == SETTLE) || (r_state == CAPTURE);
  assign done     = (r_state == DONE);
  assign resp_bit = r_resp;
  assign tie      = r_tie;
  assign err      = r_err;
  assign cnt_a    = r_cnt_a;
  assign cnt_b    = r_cnt_b;

endmodule
